// File: rtl/wb_bus_pkg.sv
// Shared SoC Wishbone definitions: arbiter state codes, master IDs (matching the
// bus-mux select encoding) and watchdog defaults.
package wb_bus_pkg;

   localparam logic [1:0] ARB_IDLE = 2'd0;
   localparam logic [1:0] ARB_CPU  = 2'd1;
   localparam logic [1:0] ARB_EXT  = 2'd2;

   localparam logic MASTER_CPU = 1'b0;
   localparam logic MASTER_EXT = 1'b1;

   localparam int unsigned WB_TIMEOUT_DEFAULT       = 255;
   localparam int unsigned WB_TIMEOUT_WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE = ARB_IDLE,
      ST_CPU  = ARB_CPU,
      ST_EXT  = ARB_EXT
   } arb_state_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Request/grant/ack bundle between the two Wishbone masters, the bus mux and the arbiter.
interface wb_arbiter_if;

   logic wb_cpu_cyc_i;
   logic wb_cpu_stb_i;
   logic wb_ext_cyc_i;
   logic wb_ext_stb_i;
   logic wb_bus_ack_i;
   logic bus_master_o;
   logic wb_cpu_gnt_o;
   logic wb_ext_gnt_o;
   logic wb_cpu_ack_o;
   logic wb_ext_ack_o;
   logic wb_cpu_err_o;
   logic wb_ext_err_o;

   modport slave (
      input  wb_cpu_cyc_i, wb_cpu_stb_i, wb_ext_cyc_i, wb_ext_stb_i, wb_bus_ack_i,
      output bus_master_o, wb_cpu_gnt_o, wb_ext_gnt_o,
      output wb_cpu_ack_o, wb_ext_ack_o, wb_cpu_err_o, wb_ext_err_o
   );

   modport master (
      output wb_cpu_cyc_i, wb_cpu_stb_i, wb_ext_cyc_i, wb_ext_stb_i, wb_bus_ack_i,
      input  bus_master_o, wb_cpu_gnt_o, wb_ext_gnt_o,
      input  wb_cpu_ack_o, wb_ext_ack_o, wb_cpu_err_o, wb_ext_err_o
   );

endinterface

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts owner strobe cycles without ack and emits a one-cycle
// registered error pulse to the owning master at the terminal count.
module wb_watchdog
   import wb_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT,
   parameter int unsigned TIMEOUT_WIDTH  = WB_TIMEOUT_WIDTH_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic cpu_active,
   input  logic ext_active,
   input  logic ack,
   output logic cpu_err,
   output logic ext_err
);

   localparam logic [TIMEOUT_WIDTH-1:0] TERMINAL = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_WIDTH-1:0] count;
   logic                     active;
   logic                     expire;

   assign active = cpu_active | ext_active;
   // An ack in the terminal cycle completes the transfer, so it suppresses the error.
   assign expire = active & ~ack & (count == TERMINAL);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count   <= '0;
         cpu_err <= 1'b0;
         ext_err <= 1'b0;
      end else begin
         cpu_err <= expire & cpu_active;
         ext_err <= expire & ext_active;
         if (!active || ack || expire) begin
            count <= '0;
         end else if (count != '1) begin
            count <= count + TIMEOUT_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master (CPU / external) Wishbone arbiter with grant-gated acks.
// Optional stall watchdog enabled by defining WB_ARBITER_TIMEOUT_EN.
module wb_arbiter
   import wb_bus_pkg::*;
#(
   parameter int unsigned EXT_PRIORITY   = 0,
   parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT,
   parameter int unsigned TIMEOUT_WIDTH  = WB_TIMEOUT_WIDTH_DEFAULT
) (
   input  logic         clk_i,
   input  logic         rst_i,
   wb_arbiter_if.slave  bus
);

   if (TIMEOUT_CYCLES < 32'd2 || TIMEOUT_CYCLES > 32'd65535 ||
       TIMEOUT_CYCLES > (32'd1 << TIMEOUT_WIDTH)) begin : g_bad_cfg
      $error("wb_arbiter: TIMEOUT_CYCLES does not fit 2..65535 / TIMEOUT_WIDTH");
   end

   arb_state_e state;
   arb_state_e state_next;
   logic       last_grant;
   logic       last_grant_next;
   logic       bus_master;
   logic       bus_master_next;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         last_grant <= MASTER_EXT;
         bus_master <= MASTER_CPU;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
         bus_master <= bus_master_next;
      end
   end

   // Owners keep the bus for their whole cyc; handover always passes through IDLE.
   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      bus_master_next = bus_master;
      case (state)
         ST_IDLE: begin
            if (bus.wb_cpu_cyc_i && bus.wb_ext_cyc_i) begin
               if (EXT_PRIORITY != 0 || last_grant == MASTER_CPU) state_next = ST_EXT;
               else                                                state_next = ST_CPU;
            end else if (bus.wb_cpu_cyc_i) begin
               state_next = ST_CPU;
            end else if (bus.wb_ext_cyc_i) begin
               state_next = ST_EXT;
            end
         end
         ST_CPU:  if (!bus.wb_cpu_cyc_i) state_next = ST_IDLE;
         ST_EXT:  if (!bus.wb_ext_cyc_i) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      if (state == ST_IDLE && state_next == ST_CPU) begin
         last_grant_next = MASTER_CPU;
         bus_master_next = MASTER_CPU;
      end else if (state == ST_IDLE && state_next == ST_EXT) begin
         last_grant_next = MASTER_EXT;
         bus_master_next = MASTER_EXT;
      end
   end

   assign bus.bus_master_o = bus_master;
   assign bus.wb_cpu_gnt_o = (state == ST_CPU);
   assign bus.wb_ext_gnt_o = (state == ST_EXT);
   assign bus.wb_cpu_ack_o = bus.wb_bus_ack_i & (state == ST_CPU);
   assign bus.wb_ext_ack_o = bus.wb_bus_ack_i & (state == ST_EXT);

`ifdef WB_ARBITER_TIMEOUT_EN
   logic cpu_active;
   logic ext_active;

   assign cpu_active = (state == ST_CPU) & bus.wb_cpu_stb_i;
   assign ext_active = (state == ST_EXT) & bus.wb_ext_stb_i;

   wb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
   ) u_watchdog (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .cpu_active (cpu_active),
      .ext_active (ext_active),
      .ack        (bus.wb_bus_ack_i),
      .cpu_err    (bus.wb_cpu_err_o),
      .ext_err    (bus.wb_ext_err_o)
   );
`else
   // Strobes only matter to the watchdog.
   logic unused_stb;
   assign unused_stb = bus.wb_cpu_stb_i ^ bus.wb_ext_stb_i;

   assign bus.wb_cpu_err_o = 1'b0;
   assign bus.wb_ext_err_o = 1'b0;
`endif

endmodule
